// File: rtl/hs4_sync_source.sv
// hs4_sync_source: clocked valid/ready front end feeding a 4-phase bundled-data
// req/ack pipeline. Words are queued in a small FIFO, presented on data_out for
// SETUP_CYC cycles, then handshaked with a full return-to-zero cycle against the
// synchronized ack_in. A sticky err flags ack timeouts and acks without a request.
module hs4_sync_source #(
   parameter int DATA_W      = 3,
   parameter int DEPTH       = 4,
   parameter int SETUP_CYC   = 2,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [DATA_W-1:0]        data_out,
   output logic                     req_out,
   input  logic                     ack_in,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] REQ_HI = 2'd2;
   localparam logic [1:0] RTZ    = 2'd3;

   logic [1:0]             state;
   logic [DATA_W-1:0]      mem [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ack_s;
   logic                   ack_s_d;
   logic [SW-1:0]          cnt;
   logic [TW-1:0]          tmo;
   logic                   push;
   logic                   pop;

   assign ack_s    = sync_q[SYNC_STAGES-1];
   assign wr_ready = (count != FULL_CNT);
   assign push     = wr_valid & wr_ready;
   // A new word is only launched once the pipeline has returned ack to zero.
   assign pop      = (state == IDLE) && (count != '0) && !ack_s;
   assign busy     = (state != IDLE);

   // FIFO storage; contents need no reset since pointers and count gate reads.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Synchronizer for the asynchronous ack, plus one delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         ack_s_d <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_in};
         ack_s_d <= ack_s;
      end
   end

   // Handshake sequencer: load, setup margin, request high, return to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         data_out <= '0;
         req_out  <= 1'b0;
         cnt      <= '0;
         tmo      <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  data_out <= mem[rd_ptr];
                  cnt      <= SETUP_LOAD;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (ack_s && !ack_s_d) begin
                  err <= 1'b1;
               end
               if (cnt == '0) begin
                  req_out <= 1'b1;
                  tmo     <= '0;
                  state   <= REQ_HI;
               end else begin
                  cnt <= cnt - SW'(1);
               end
            end
            REQ_HI: begin
               if (ack_s) begin
                  req_out <= 1'b0;
                  tmo     <= '0;
                  state   <= RTZ;
               end else if (tmo != TMO_MAX) begin
                  tmo <= tmo + TW'(1);
               end
            end
            RTZ: begin
               if (!ack_s) begin
                  state <= IDLE;
               end else if (tmo != TMO_MAX) begin
                  tmo <= tmo + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
         // Timeout only flags the condition; the sequencer keeps waiting for ack.
         if (((state == REQ_HI) || (state == RTZ)) && (tmo == TMO_MAX)) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hs4_sync_source.sv
// tb_hs4_sync_source: directed test of hs4_sync_source with a small ack model
// (either echoing req_out one cycle late, or driven by hand).
module tb_hs4_sync_source;

   logic       clk;
   logic       rst_n;
   logic [2:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] data_out;
   logic       req_out;
   logic       ack_in;
   logic [2:0] count;
   logic       busy;
   logic       err;

   logic       ack_auto;
   logic       ack_man;
   logic       ack_echo;

   int unsigned checks;
   int unsigned errors;

   hs4_sync_source #(
      .DATA_W      (3),
      .DEPTH       (4),
      .SETUP_CYC   (2),
      .SYNC_STAGES (2),
      .TIMEOUT     (255)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .data_out (data_out),
      .req_out  (req_out),
      .ack_in   (ack_in),
      .count    (count),
      .busy     (busy),
      .err      (err)
   );

   assign ack_in = ack_auto ? ack_echo : ack_man;

   always #5 clk = ~clk;

   // Pipeline model: acknowledges one cycle after req changes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ack_echo <= 1'b0;
      else        ack_echo <= req_out;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [2:0] v);
      wr_data  = v;
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_req(input logic lvl, input string tag);
      int unsigned n = 0;
      while (req_out !== lvl && n < 600) begin
         tick();
         n++;
      end
      check(tag, {31'b0, req_out}, {31'b0, lvl});
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      while (busy !== 1'b0 && n < 600) begin
         tick();
         n++;
      end
      check(tag, {31'b0, busy}, 32'd0);
   endtask

   // One word seen on the pipeline: value at req rise, held during req high and RTZ.
   task automatic xfer(input logic [2:0] exp);
      int unsigned n = 0;
      wait_req(1'b1, "xfer_req_hi");
      check("xfer_data", {29'b0, data_out}, {29'b0, exp});
      while (req_out === 1'b1 && n < 600) begin
         check("xfer_hold", {29'b0, data_out}, {29'b0, exp});
         tick();
         n++;
      end
      check("xfer_req_lo", {31'b0, req_out}, 32'd0);
      check("xfer_rtz_data", {29'b0, data_out}, {29'b0, exp});
   endtask

   task automatic do_reset();
      ack_auto = 1'b0;
      ack_man  = 1'b0;
      wr_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int unsigned n;
      clk      = 1'b0;
      rst_n    = 1'b0;
      wr_data  = '0;
      wr_valid = 1'b0;
      ack_man  = 1'b0;
      ack_auto = 1'b0;
      checks   = 0;
      errors   = 0;

      // Power-on reset values
      tick();
      tick();
      check("rst_req",   {31'b0, req_out},  32'd0);
      check("rst_data",  {29'b0, data_out}, 32'd0);
      check("rst_count", {29'b0, count},    32'd0);
      check("rst_err",   {31'b0, err},      32'd0);
      check("rst_busy",  {31'b0, busy},     32'd0);
      check("rst_ready", {31'b0, wr_ready}, 32'd1);
      rst_n = 1'b1;
      tick();

      // Reset mid-REQ_HI with three words queued
      for (int i = 1; i <= 4; i++) begin
         wr_data  = 3'(i);
         wr_valid = 1'b1;
         tick();
      end
      wr_valid = 1'b0;
      tick();
      tick();
      check("t1_pre_req",   {31'b0, req_out}, 32'd1);
      check("t1_pre_count", {29'b0, count},   32'd3);
      rst_n = 1'b0;
      #1;
      check("t1_req",   {31'b0, req_out},  32'd0);
      check("t1_data",  {29'b0, data_out}, 32'd0);
      check("t1_count", {29'b0, count},    32'd0);
      check("t1_err",   {31'b0, err},      32'd0);
      check("t1_ready", {31'b0, wr_ready}, 32'd1);
      check("t1_busy",  {31'b0, busy},     32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single word with echoing ack: exact edge timing
      ack_auto = 1'b1;
      push_word(3'b001);                                   // edge N
      check("t2_cnt_n",  {29'b0, count},    32'd1);
      check("t2_data_n", {29'b0, data_out}, 32'd0);
      tick();                                              // N+1
      check("t2_data_n1", {29'b0, data_out}, 32'd1);
      check("t2_req_n1",  {31'b0, req_out},  32'd0);
      check("t2_cnt_n1",  {29'b0, count},    32'd0);
      check("t2_busy_n1", {31'b0, busy},     32'd1);
      tick();                                              // N+2
      check("t2_req_n2", {31'b0, req_out}, 32'd0);
      tick();                                              // N+3
      check("t2_req_n3", {31'b0, req_out}, 32'd1);
      tick();
      tick();
      tick();                                              // N+6
      check("t2_req_n6", {31'b0, req_out}, 32'd1);
      tick();                                              // N+7
      check("t2_req_n7", {31'b0, req_out}, 32'd0);
      wait_idle("t2_idle");
      check("t2_data_end", {29'b0, data_out}, 32'd1);

      // Burst of five back-to-back words
      for (int i = 1; i <= 5; i++) begin
         wr_data  = 3'(i);
         wr_valid = 1'b1;
         tick();
      end
      wr_valid = 1'b0;
      check("t3_full_cnt",   {29'b0, count},    32'd4);
      check("t3_full_ready", {31'b0, wr_ready}, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         xfer(3'(i));
      end
      wait_idle("t3_idle");
      check("t3_cnt_end",   {29'b0, count},    32'd0);
      check("t3_ready_end", {31'b0, wr_ready}, 32'd1);

      // Stuck ack: timeout sets err, req stays high, FSM keeps waiting
      ack_auto = 1'b0;
      ack_man  = 1'b0;
      push_word(3'b110);
      wait_req(1'b1, "t4_req");
      check("t4_data", {29'b0, data_out}, 32'd6);
      repeat (250) tick();
      check("t4_err_early", {31'b0, err},     32'd0);
      check("t4_req_early", {31'b0, req_out}, 32'd1);
      repeat (10) tick();
      check("t4_err_late", {31'b0, err},     32'd1);
      check("t4_req_late", {31'b0, req_out}, 32'd1);
      ack_man = 1'b1;
      wait_req(1'b0, "t4_fall");
      check("t4_err_after_ack", {31'b0, err}, 32'd1);
      ack_man = 1'b0;
      wait_idle("t4_idle");
      check("t4_err_sticky", {31'b0, err}, 32'd1);

      // Late RTZ: next word waits until ack_s returns low
      push_word(3'b011);
      push_word(3'b101);
      wait_req(1'b1, "t5_req");
      check("t5_data_a", {29'b0, data_out}, 32'd3);
      check("t5_cnt_a",  {29'b0, count},    32'd1);
      ack_man = 1'b1;
      wait_req(1'b0, "t5_fall");
      repeat (20) tick();
      check("t5_hold_busy", {31'b0, busy},     32'd1);
      check("t5_hold_cnt",  {29'b0, count},    32'd1);
      check("t5_hold_data", {29'b0, data_out}, 32'd3);
      check("t5_hold_req",  {31'b0, req_out},  32'd0);
      ack_man = 1'b0;
      n = 0;
      while (data_out !== 3'b101 && n < 20) begin
         tick();
         n++;
      end
      check("t5_data_b", {29'b0, data_out}, 32'd5);
      check("t5_cnt_b",  {29'b0, count},    32'd0);
      wait_req(1'b1, "t5_req_b");
      ack_man = 1'b1;
      wait_req(1'b0, "t5_fall_b");
      ack_man = 1'b0;
      wait_idle("t5_idle");

      // Spurious ack during SETUP: err set, req still rises on schedule
      do_reset();
      check("t6_err_rst", {31'b0, err}, 32'd0);
      push_word(3'b010);                                   // edge N
      ack_man = 1'b1;
      tick();                                              // N+1
      ack_man = 1'b0;
      check("t6_data_n1", {29'b0, data_out}, 32'd2);
      check("t6_req_n1",  {31'b0, req_out},  32'd0);
      check("t6_err_n1",  {31'b0, err},      32'd0);
      tick();                                              // N+2
      check("t6_req_n2", {31'b0, req_out}, 32'd0);
      check("t6_err_n2", {31'b0, err},     32'd0);
      tick();                                              // N+3
      check("t6_req_n3", {31'b0, req_out}, 32'd1);
      check("t6_err_n3", {31'b0, err},     32'd1);
      repeat (5) tick();
      check("t6_req_hold", {31'b0, req_out}, 32'd1);
      ack_man = 1'b1;
      wait_req(1'b0, "t6_fall");
      ack_man = 1'b0;
      wait_idle("t6_idle");
      check("t6_err_sticky", {31'b0, err}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
